// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic library (adder, multiplier, divider).
// Holds the default Q format, the sequencer state encoding and the saturation limits.
package fixed_point_pkg;

  localparam int DEF_N = 16;
  localparam int DEF_F = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } fxp_state_e;

  // Largest positive two's-complement value for an n-bit word, zero-extended to 64 bits.
  function automatic logic [63:0] max_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative n-bit value (equal to its magnitude).
  function automatic logic [63:0] min_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division step: shift a dividend bit into the remainder and
// trial-subtract the divisor magnitude, keeping the difference when it is non-negative.
module fixed_point_divider_div_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // One extra bit so the borrow of the subtraction is visible as the sign.
  assign shifted = {rem, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[W];
  assign rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q(N-F).F divider: one quotient bit per cycle, fixed latency,
// saturating result with overflow/negative/divide-by-zero flags, valid/ready on both sides.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int F = DEF_F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow_flag,
  output logic         negative,
  output logic         div_by_zero
);

  localparam int QW = N + F;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST    = CW'(QW - 1);
  localparam logic [N-1:0]  MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0]  MIN_NEG = N'(min_neg(N));
  localparam logic [QW-1:0] POS_LIM = QW'(max_pos(N));
  localparam logic [QW-1:0] NEG_LIM = QW'(min_neg(N));

  fxp_state_e state, state_nxt;

  logic [N-1:0]  a_q, b_q;
  logic [N:0]    mag_a, mag_b;
  logic [N:0]    divisor_q;
  logic [QW-1:0] dvd_q;
  logic [N:0]    rem_q, rem_nxt;
  logic [QW-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q, dbz_q;
  logic          q_bit;

  logic [N-1:0]  fix_res;
  logic          fix_ovf, fix_neg;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // N+1 bits so that the magnitude of the most negative operand is representable.
  assign mag_a = a_q[N-1] ? ((N+1)'(0) - {a_q[N-1], a_q}) : {a_q[N-1], a_q};
  assign mag_b = b_q[N-1] ? ((N+1)'(0) - {b_q[N-1], b_q}) : {b_q[N-1], b_q};

  fixed_point_divider_div_step #(.W(N + 1)) u_step (
    .rem     (rem_q),
    .bit_in  (dvd_q[QW-1]),
    .divisor (divisor_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt_q == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign application and saturation of the unsigned quotient magnitude.
  always_comb begin
    fix_res = quo_q[N-1:0];
    fix_ovf = 1'b0;
    fix_neg = neg_q;
    if (dbz_q) begin
      fix_res = a_q[N-1] ? MIN_NEG : MAX_POS;
      fix_ovf = 1'b1;
      fix_neg = a_q[N-1];
    end else if (neg_q) begin
      if (quo_q > NEG_LIM) begin
        fix_res = MIN_NEG;
        fix_ovf = 1'b1;
      end else begin
        fix_res = N'(0) - quo_q[N-1:0];
      end
    end else if (quo_q > POS_LIM) begin
      fix_res = MAX_POS;
      fix_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      divisor_q     <= '0;
      dvd_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      dbz_q         <= 1'b0;
      result        <= '0;
      overflow_flag <= 1'b0;
      negative      <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= A;
          b_q <= B;
        end
        PREP: begin
          // |A| never exceeds 2^(N-1), so the top magnitude bit is always zero here.
          dvd_q     <= QW'({mag_a, {F{1'b0}}});
          divisor_q <= mag_b;
          rem_q     <= '0;
          quo_q     <= '0;
          cnt_q     <= '0;
          neg_q     <= (a_q != '0) && (a_q[N-1] ^ b_q[N-1]);
          dbz_q     <= (b_q == '0);
        end
        CALC: begin
          dvd_q <= {dvd_q[QW-2:0], 1'b0};
          rem_q <= rem_nxt;
          quo_q <= {quo_q[QW-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          result        <= fix_res;
          overflow_flag <= fix_ovf;
          negative      <= fix_neg;
          div_by_zero   <= dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed cases, random operands against
// an arithmetic reference, backpressure, busy-time operand rejection and mid-run reset.
module tb_fixed_point_divider;

  localparam int N   = 16;
  localparam int F   = 8;
  localparam int LAT = N + F + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] A, B, result;
  logic         overflow_flag, negative, div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_divider #(.N(N), .F(F)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (A),
    .B             (B),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .overflow_flag (overflow_flag),
    .negative      (negative),
    .div_by_zero   (div_by_zero)
  );

  // Reference: exact signed rational quotient, truncated toward zero, then saturated.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ovf,
                                output logic neg, output logic dbz);
    longint sa, sb, q;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = (b == 16'h0);
    ovf = 1'b0;
    if (dbz) begin
      r   = a[15] ? 16'h8000 : 16'h7FFF;
      ovf = 1'b1;
      neg = a[15];
    end else begin
      q   = (sa * (longint'(1) << F)) / sb;
      neg = (a != 16'h0) && (a[15] != b[15]);
      if (q > 32767) begin
        r = 16'h7FFF; ovf = 1'b1;
      end else if (q < -32768) begin
        r = 16'h8000; ovf = 1'b1;
      end else begin
        r = q[15:0];
      end
    end
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input int acc, output int lat);
    int n;
    n = 0;
    lat = -1;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: out_valid stayed 0 for %0d cycles", n);
    end else begin
      lat = cyc - acc;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic ovf, output logic neg,
                       output logic dbz, output int lat);
    int acc;
    out_ready = 1'b1;
    send(a, b, acc);
    wait_valid(acc, lat);
    r = result; ovf = overflow_flag; neg = negative; dbz = div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h exp 0000", result); end
    checks++; if ({overflow_flag, negative, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b exp 000", {overflow_flag, negative, div_by_zero});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] r; logic ovf, neg, dbz; int lat;
    do_op(16'h0600, 16'h0200, r, ovf, neg, dbz, lat);
    checks++; if (r !== 16'h0300) begin errors++; $display("FAIL basic_result: got %h exp 0300", r); end
    checks++; if ({ovf, neg, dbz} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b exp 000", {ovf, neg, dbz}); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [6] = '{16'hF880, 16'h0100, 16'h0100, 16'h8000, 16'h7F00, 16'h8000};
    logic [15:0] tb [6] = '{16'h0280, 16'h0300, 16'h0000, 16'h0000, 16'h0001, 16'hFF00};
    logic [15:0] tr [6] = '{16'hFD00, 16'h0055, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic [15:0] r, er; logic ovf, neg, dbz, eovf, eneg, edbz; int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], r, ovf, neg, dbz, lat);
      model(ta[i], tb[i], er, eovf, eneg, edbz);
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h exp %h", i, r, tr[i]); end
      checks++; if ({ovf, neg, dbz} !== {eovf, eneg, edbz}) begin
        errors++; $display("FAIL directed_flags[%0d]: got %b exp %b", i, {ovf, neg, dbz}, {eovf, eneg, edbz});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, er; logic ovf, neg, dbz, eovf, eneg, edbz; int lat;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'h0000;
        1: a = 16'h8000;
        2: a = 16'($urandom_range(0, 1023));
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: b = 16'h0000;
        1: b = 16'h0001;
        2: b = 16'hFFFF;
        3: b = 16'h8000;
        4: b = 16'($urandom_range(1, 2047)) ^ ($urandom_range(0, 1) != 0 ? 16'hFFFF : 16'h0000);
        default: b = 16'($urandom);
      endcase
      do_op(a, b, r, ovf, neg, dbz, lat);
      model(a, b, er, eovf, eneg, edbz);
      checks++;
      if (r !== er || {ovf, neg, dbz} !== {eovf, eneg, edbz} || lat != LAT) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got r=%h f=%b lat=%0d exp r=%h f=%b lat=%0d",
                 i, a, b, r, {ovf, neg, dbz}, lat, er, {eovf, eneg, edbz}, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] cap, er; logic [2:0] capf; logic eovf, eneg, edbz;
    int acc, h, lat, n; bit leak;
    out_ready = 1'b0;
    send(16'h0A00, 16'h0400, acc);
    // Offer a second operation while the first is in flight.
    @(negedge clk);
    A = 16'h0300; B = 16'hFE00; in_valid = 1'b1;
    leak = 0; n = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) leak = 1;
      @(negedge clk);
      n++;
    end
    checks++; if (leak || !out_valid) begin errors++; $display("FAIL busy_in_ready: leak=%0d valid=%b exp leak=0 valid=1", leak, out_valid); end
    model(16'h0A00, 16'h0400, er, eovf, eneg, edbz);
    cap = result; capf = {overflow_flag, negative, div_by_zero};
    checks++; if (cap !== er || capf !== {eovf, eneg, edbz}) begin
      errors++; $display("FAIL bp_first_result: got %h/%b exp %h/%b", cap, capf, er, {eovf, eneg, edbz});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== cap ||
          {overflow_flag, negative, div_by_zero} !== capf) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b r=%h f=%b exp v=1 rdy=0 r=%h f=%b", i, out_valid,
                 in_ready, result, {overflow_flag, negative, div_by_zero}, cap, capf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    h = cyc;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(h, lat);
    model(16'h0300, 16'hFE00, er, eovf, eneg, edbz);
    checks++; if (result !== er || {overflow_flag, negative, div_by_zero} !== {eovf, eneg, edbz} || lat != LAT + 1) begin
      errors++; $display("FAIL bp_second: got r=%h f=%b lat=%0d exp r=%h f=%b lat=%0d", result,
                         {overflow_flag, negative, div_by_zero}, lat, er, {eovf, eneg, edbz}, LAT + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic ovf, neg, dbz; int acc, lat; bit seen;
    out_ready = 1'b1;
    send(16'h0600, 16'h0200, acc);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 ||
        {overflow_flag, negative, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b r=%h f=%b exp rdy=1 v=0 r=0000 f=000",
               in_ready, out_valid, result, {overflow_flag, negative, div_by_zero});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_valid: got out_valid=1 exp 0"); end
    do_op(16'h0600, 16'h0200, r, ovf, neg, dbz, lat);
    checks++; if (r !== 16'h0300 || {ovf, neg, dbz} !== 3'b000 || lat != LAT) begin
      errors++; $display("FAIL midreset_fresh: got r=%h f=%b lat=%0d exp r=0300 f=000 lat=%0d", r, {ovf, neg, dbz}, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
